// File: rtl/add_sched_pkg.sv
// Shared types and helpers for the add_sched round-robin adder scheduler.
// Build option: ADD_SCHED_SAT_EN selects a saturating result instead of wrap-around.
package add_sched_pkg;

   localparam int N_REQ_DEF = 4;
   localparam int W_DEF     = 11;
   localparam int MAX_W     = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   // Choose the value presented on sum_out from the low add bits and the carry.
   function automatic logic [MAX_W-1:0] fold_result(
      input logic [MAX_W-1:0] low,
      input logic             carry,
      input logic [MAX_W-1:0] ones
   );
`ifdef ADD_SCHED_SAT_EN
      return carry ? ones : low;
`else
      return carry ? (low & ones) : low;
`endif
   endfunction

endpackage

// File: rtl/add_sched_rr_arbiter.sv
// Combinational round-robin arbiter: lowest offset from ptr (with wrap) wins.
module rr_arbiter
   import add_sched_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int PW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PW-1:0]    ptr,
   output logic [N_REQ-1:0] gnt,
   output logic             valid
);

   logic [PW-1:0] w_idx;

   // Walk offsets from the far end toward ptr so the nearest requester is assigned last.
   always_comb begin
      gnt   = '0;
      valid = 1'b0;
      w_idx = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         w_idx = PW'((int'(ptr) + k) % N_REQ);
         if (req[w_idx]) begin
            gnt        = '0;
            gnt[w_idx] = 1'b1;
            valid      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/add_sched.sv
// Round-robin scheduler sharing one W-bit adder between N_REQ requesters.
// Build option: define ADD_SCHED_SAT_EN to clamp sum_out to all-ones on carry.
module add_sched
   import add_sched_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int W     = W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ*W-1:0] m_in,
   input  logic [N_REQ*W-1:0] s_in,
   output logic [N_REQ-1:0]   gnt,
   output logic [N_REQ-1:0]   done,
   output logic [W-1:0]       sum_out,
   output logic               ovf
);

   localparam int PW = $clog2(N_REQ);
   localparam logic [MAX_W-1:0] ONES = (MAX_W'(1) << W) - MAX_W'(1);

   state_t           r_state;
   logic [PW-1:0]    r_ptr;
   logic [PW-1:0]    r_win;
   logic [N_REQ-1:0] r_gnt;
   logic [N_REQ-1:0] r_done;
   logic [W-1:0]     r_m;
   logic [W-1:0]     r_s;
   logic [W-1:0]     r_sum;
   logic             r_ovf;

   logic [N_REQ-1:0] w_gnt;
   logic             w_valid;
   logic [PW-1:0]    w_win_idx;
   logic [W-1:0]     w_m_sel;
   logic [W-1:0]     w_s_sel;
   logic [W:0]       w_add;
   logic [W-1:0]     w_result;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .PW    (PW)
   ) u_arb (
      .req   (req),
      .ptr   (r_ptr),
      .gnt   (w_gnt),
      .valid (w_valid)
   );

   // One-hot grant drives both the operand mux and the winner index encoder.
   always_comb begin
      w_m_sel   = '0;
      w_s_sel   = '0;
      w_win_idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_gnt[i]) begin
            w_m_sel   = m_in[i*W +: W];
            w_s_sel   = s_in[i*W +: W];
            w_win_idx = PW'(i);
         end
      end
   end

   assign w_add    = {1'b0, r_m} + {1'b0, r_s};
   assign w_result = W'(fold_result(MAX_W'(w_add[W-1:0]), w_add[W], ONES));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_win   <= '0;
         r_gnt   <= '0;
         r_done  <= '0;
         r_m     <= '0;
         r_s     <= '0;
         r_sum   <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_done <= '0;
         case (r_state)
            IDLE: begin
               if (w_valid) begin
                  r_m     <= w_m_sel;
                  r_s     <= w_s_sel;
                  r_win   <= w_win_idx;
                  r_gnt   <= w_gnt;
                  r_state <= EXEC;
               end
            end
            EXEC: begin
               r_sum   <= w_result;
               r_ovf   <= w_add[W];
               r_done  <= r_gnt;
               r_state <= RESP;
            end
            RESP: begin
               r_ptr   <= (r_win == PW'(N_REQ - 1)) ? '0 : r_win + 1'b1;
               r_gnt   <= '0;
               r_state <= IDLE;
            end
            default: begin
               r_gnt   <= '0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign gnt     = r_gnt;
   assign done    = r_done;
   assign sum_out = r_sum;
   assign ovf     = r_ovf;

endmodule

// File: tb/tb_add_sched.sv
// Directed self-checking bench for add_sched (N_REQ=4, W=11); honours ADD_SCHED_SAT_EN.
module tb_add_sched;

   localparam int N = 4;
   localparam int W = 11;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req = '0;
   logic [N*W-1:0] m_in = '0;
   logic [N*W-1:0] s_in = '0;
   logic [N-1:0]   gnt;
   logic [N-1:0]   done;
   logic [W-1:0]   sum_out;
   logic           ovf;

   int checks   = 0;
   int failures = 0;

   add_sched #(.N_REQ(N), .W(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .m_in    (m_in),
      .s_in    (s_in),
      .gnt     (gnt),
      .done    (done),
      .sum_out (sum_out),
      .ovf     (ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      int           idx;
      logic [W-1:0] m;
      logic [W-1:0] s;
      logic [W-1:0] exp_sum;
      logic         exp_ovf;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end else begin
         $display("ok   %s: %0d", name, act);
      end
   endtask

   task automatic edge_sample();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ops(input int idx, input logic [W-1:0] m, input logic [W-1:0] s);
      m_in[idx*W +: W] = m;
      s_in[idx*W +: W] = s;
   endtask

   // One isolated request: gnt after one edge, done after two, idle after three.
   task automatic run_single(input int idx, input logic [W-1:0] m, input logic [W-1:0] s,
                             input logic [W-1:0] exp_sum, input logic exp_ovf);
      logic [N-1:0] oh;
      oh = N'(1) << idx;
      @(negedge clk);
      set_ops(idx, m, s);
      req = oh;
      edge_sample();
      check($sformatf("single%0d gnt", idx), 32'(gnt), 32'(oh));
      check($sformatf("single%0d done_early", idx), 32'(done), 0);
      edge_sample();
      check($sformatf("single%0d done", idx), 32'(done), 32'(oh));
      check($sformatf("single%0d sum", idx), 32'(sum_out), 32'(exp_sum));
      check($sformatf("single%0d ovf", idx), 32'(ovf), 32'(exp_ovf));
      req = '0;
      edge_sample();
      check($sformatf("single%0d done_off", idx), 32'(done), 0);
      check($sformatf("single%0d gnt_off", idx), 32'(gnt), 0);
   endtask

   initial begin
      vecs[0] = '{idx: 0, m: 11'd1000, s: 11'd500,  exp_sum: 11'd1500, exp_ovf: 1'b0};
`ifdef ADD_SCHED_SAT_EN
      vecs[1] = '{idx: 1, m: 11'd2000, s: 11'd100,  exp_sum: 11'd2047, exp_ovf: 1'b1};
      vecs[2] = '{idx: 2, m: 11'd2047, s: 11'd2047, exp_sum: 11'd2047, exp_ovf: 1'b1};
      vecs[5] = '{idx: 1, m: 11'd1024, s: 11'd1024, exp_sum: 11'd2047, exp_ovf: 1'b1};
`else
      vecs[1] = '{idx: 1, m: 11'd2000, s: 11'd100,  exp_sum: 11'd52,   exp_ovf: 1'b1};
      vecs[2] = '{idx: 2, m: 11'd2047, s: 11'd2047, exp_sum: 11'd2046, exp_ovf: 1'b1};
      vecs[5] = '{idx: 1, m: 11'd1024, s: 11'd1024, exp_sum: 11'd0,    exp_ovf: 1'b1};
`endif
      vecs[3] = '{idx: 3, m: 11'd0,    s: 11'd0,    exp_sum: 11'd0,    exp_ovf: 1'b0};
      vecs[4] = '{idx: 0, m: 11'd1024, s: 11'd1023, exp_sum: 11'd2047, exp_ovf: 1'b0};

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset gnt", 32'(gnt), 0);
      check("reset done", 32'(done), 0);
      check("reset sum", 32'(sum_out), 0);
      check("reset ovf", 32'(ovf), 0);

      for (int v = 0; v < 6; v++)
         run_single(vecs[v].idx, vecs[v].m, vecs[v].s, vecs[v].exp_sum, vecs[v].exp_ovf);

      // Reset mid-EXEC: requester 0 leaves ptr=1 and sum=3, then requester 1 is abandoned.
      run_single(0, 11'd1, 11'd2, 11'd3, 1'b0);
      @(negedge clk);
      set_ops(1, 11'd5, 11'd7);
      req = 4'b0010;
      edge_sample();
      check("rstexec gnt", 32'(gnt), 32'h2);
      @(negedge clk);
      rst = 1'b1;
      edge_sample();
      check("rstexec done", 32'(done), 0);
      check("rstexec gnt_clr", 32'(gnt), 0);
      check("rstexec sum", 32'(sum_out), 0);
      check("rstexec ovf", 32'(ovf), 0);
      @(negedge clk);
      rst = 1'b0;
      req = 4'b0000;
      edge_sample();
      edge_sample();
      check("rstexec no_done", 32'(done), 0);
      // ptr must be back at 0: with 0 and 1 requesting, 0 wins.
      @(negedge clk);
      set_ops(0, 11'd10, 11'd20);
      req = 4'b0011;
      edge_sample();
      check("rstexec ptr gnt", 32'(gnt), 32'h1);
      edge_sample();
      check("rstexec ptr done", 32'(done), 32'h1);
      check("rstexec ptr sum", 32'(sum_out), 30);
      req = 4'b0000;
      edge_sample();
      edge_sample();
      check("rstexec idle", 32'(gnt), 0);

      // Round-robin with all four held, from a fresh ptr=0.
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      set_ops(0, 11'd11, 11'd1);
      set_ops(1, 11'd22, 11'd2);
      set_ops(2, 11'd33, 11'd3);
      set_ops(3, 11'd44, 11'd4);
      req = 4'b1111;
      for (int t = 0; t < 4; t++) begin
         edge_sample();
         check($sformatf("rr%0d gnt", t), 32'(gnt), 32'(1 << t));
         edge_sample();
         check($sformatf("rr%0d done", t), 32'(done), 32'(1 << t));
         check($sformatf("rr%0d sum", t), 32'(sum_out), 32'(12 * (t + 1)));
         req[t] = 1'b0;
         edge_sample();
         check($sformatf("rr%0d gap", t), 32'(done), 0);
      end
      // ptr is now 0. Move it to 1 so the late-arrival case exercises wrap.
      run_single(0, 11'd1, 11'd1, 11'd2, 1'b0);

      // Late arrival: req[2] granted, req[0] rises during EXEC and waits.
      @(negedge clk);
      set_ops(2, 11'd100, 11'd200);
      set_ops(0, 11'd300, 11'd400);
      req = 4'b0100;
      edge_sample();
      check("late gnt2", 32'(gnt), 32'h4);
      req = 4'b0101;
      edge_sample();
      check("late done2", 32'(done), 32'h4);
      check("late gnt_hold", 32'(gnt), 32'h4);
      check("late sum2", 32'(sum_out), 300);
      edge_sample();
      check("late idle", 32'(gnt), 0);
      edge_sample();
      check("late gnt0", 32'(gnt), 32'h1);
      edge_sample();
      check("late done0", 32'(done), 32'h1);
      check("late sum0", 32'(sum_out), 700);
      req = 4'b0100;
      edge_sample();
      edge_sample();
      check("late gnt2b", 32'(gnt), 32'h4);
      edge_sample();
      check("late done2b", 32'(done), 32'h4);
      req = 4'b0000;
      edge_sample();

      // Held req[3]: a second transaction follows, done spaced 3 cycles apart.
      @(negedge clk);
      set_ops(3, 11'd7, 11'd8);
      req = 4'b1000;
      edge_sample();
      check("held gnt", 32'(gnt), 32'h8);
      edge_sample();
      check("held done1", 32'(done), 32'h8);
      check("held sum1", 32'(sum_out), 15);
      edge_sample();
      check("held gap1", 32'(done), 0);
      edge_sample();
      check("held gap2", 32'(done), 0);
      check("held gnt2", 32'(gnt), 32'h8);
      edge_sample();
      check("held done2", 32'(done), 32'h8);
      req = 4'b0000;
      edge_sample();
      check("held end", 32'(done), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
